// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: bus word types, FSM states,
// request owner and the latched request record.
package mem_arbiter_pkg;

  typedef logic [31:0] rvga_word;
  typedef logic [3:0]  rvga_wmask;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP
  } rvga_memarb_state;

  typedef enum logic {
    OWNER_IMEM,
    OWNER_DMEM
  } rvga_mem_owner;

  typedef struct packed {
    rvga_mem_owner owner;
    logic          we;
    rvga_word      addr;
    rvga_word      wdata;
    rvga_wmask     wmask;
  } rvga_mem_req;

  // Chooses dmem when it is the only eligible requester, or on a tie when dmem has priority.
  function automatic logic pick_dmem(input logic ielig, input logic delig, input logic dmem_prio);
    return delig & (~ielig | dmem_prio);
  endfunction

endpackage

// File: rtl/mem_arbiter_dff.sv
// Enabled register with asynchronous active-low reset to zero.
module mem_arbiter_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else if (en_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one req/gnt/rvalid memory
// port and stalls the pipeline until every request of the current step has completed.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic dmem_priority_p = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_r_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_ready_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [3:0]  dmem_wmask_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_v_o
);

  rvga_memarb_state r_state;
  rvga_memarb_state w_state_next;
  logic             r_imem_done;
  logic             r_dmem_done;

  logic        w_dreq;
  logic        w_ielig;
  logic        w_delig;
  logic        w_pick_dmem;
  logic        w_latch;
  logic        w_resp_done;
  logic        w_ipend;
  logic        w_dpend;
  rvga_mem_req w_req_d;
  logic        w_owner_q;
  logic        w_we_q;

  assign w_dreq  = dmem_r_v_i | dmem_w_v_i;
  // A completed request still held during a stall must not be issued again.
  assign w_ielig = imem_r_v_i & ~r_imem_done;
  assign w_delig = w_dreq & ~r_dmem_done;
  assign w_pick_dmem = pick_dmem(w_ielig, w_delig, dmem_priority_p);

  always_comb begin
    w_req_d = '0;
    if (w_pick_dmem) begin
      w_req_d.owner = OWNER_DMEM;
      w_req_d.we    = dmem_w_v_i;
      w_req_d.addr  = dmem_addr_i;
      w_req_d.wdata = dmem_data_i;
      w_req_d.wmask = dmem_wmask_i;
    end else begin
      w_req_d.owner = OWNER_IMEM;
      w_req_d.addr  = imem_addr_i;
    end
  end

  mem_arbiter_dff #(.width_p($bits(rvga_word))) u_addr_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_latch),
    .d_i   (w_req_d.addr),
    .q_o   (mem_addr_o)
  );

  mem_arbiter_dff #(.width_p($bits(rvga_word))) u_wdata_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_latch),
    .d_i   (w_req_d.wdata),
    .q_o   (mem_wdata_o)
  );

  mem_arbiter_dff #(.width_p($bits(rvga_wmask))) u_wmask_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_latch),
    .d_i   (w_req_d.wmask),
    .q_o   (mem_wmask_o)
  );

  mem_arbiter_dff #(.width_p(2)) u_ctrl_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (w_latch),
    .d_i   ({w_req_d.owner, w_req_d.we}),
    .q_o   ({w_owner_q, w_we_q})
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_ielig | w_delig) begin
          w_latch      = 1'b1;
          w_state_next = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) w_state_next = MEM_RESP;
      end
      MEM_RESP: begin
        if (mem_rvalid_i) w_state_next = MEM_IDLE;
      end
      default: w_state_next = MEM_IDLE;
    endcase
  end

  assign mem_req_o   = (r_state == MEM_REQ);
  assign mem_we_o    = mem_req_o & w_we_q;
  assign w_resp_done = (r_state == MEM_RESP) & mem_rvalid_i;

  // Ready is withheld when the owner dropped its request mid-transaction.
  assign imem_ready_o = w_resp_done & (w_owner_q == OWNER_IMEM) & imem_r_v_i;
  assign dmem_ready_o = w_resp_done & (w_owner_q == OWNER_DMEM) & w_dreq;
  assign imem_data_o  = mem_rdata_i;
  assign dmem_data_o  = mem_rdata_i;

  assign w_ipend   = imem_r_v_i & ~r_imem_done & ~imem_ready_o;
  assign w_dpend   = w_dreq & ~r_dmem_done & ~dmem_ready_o;
  assign stall_v_o = w_ipend | w_dpend;

  // Done flags remember completions within a step and clear when the pipeline advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else if (!stall_v_o) begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else begin
      if (imem_ready_o) r_imem_done <= 1'b1;
      if (dmem_ready_o) r_dmem_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dmem-priority instance for most scenarios,
// plus a fetch-priority instance for the tie-break check.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        imem_r_v, dmem_r_v, dmem_w_v, gnt, rvalid;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, rdata;
  logic [3:0]  dmem_wmask;
  logic [31:0] imem_data, dmem_data, mem_addr, mem_wdata;
  logic        imem_ready, dmem_ready, mem_req, mem_we, stall;
  logic [3:0]  mem_wmask;

  logic        p_imem_r_v, p_dmem_r_v, p_gnt, p_rvalid;
  logic [31:0] p_imem_addr, p_dmem_addr;
  logic [31:0] p_imem_data, p_dmem_data, p_mem_addr, p_mem_wdata;
  logic        p_imem_ready, p_dmem_ready, p_mem_req, p_mem_we, p_stall;
  logic [3:0]  p_mem_wmask;

  int n_cmp = 0;
  int n_err = 0;
  int load_issue_cnt = 0;
  int snap;

  mem_arbiter #(.dmem_priority_p(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_r_v_i(imem_r_v), .imem_addr_i(imem_addr), .imem_data_o(imem_data), .imem_ready_o(imem_ready),
    .dmem_r_v_i(dmem_r_v), .dmem_w_v_i(dmem_w_v), .dmem_addr_i(dmem_addr), .dmem_data_i(dmem_wdata),
    .dmem_wmask_i(dmem_wmask), .dmem_data_o(dmem_data), .dmem_ready_o(dmem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .stall_v_o(stall)
  );

  mem_arbiter #(.dmem_priority_p(1'b0)) u_dut_p0 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_r_v_i(p_imem_r_v), .imem_addr_i(p_imem_addr), .imem_data_o(p_imem_data), .imem_ready_o(p_imem_ready),
    .dmem_r_v_i(p_dmem_r_v), .dmem_w_v_i(1'b0), .dmem_addr_i(p_dmem_addr), .dmem_data_i(32'h0),
    .dmem_wmask_i(4'h0), .dmem_data_o(p_dmem_data), .dmem_ready_o(p_dmem_ready),
    .mem_req_o(p_mem_req), .mem_we_o(p_mem_we), .mem_addr_o(p_mem_addr), .mem_wdata_o(p_mem_wdata),
    .mem_wmask_o(p_mem_wmask), .mem_gnt_i(p_gnt), .mem_rvalid_i(p_rvalid), .mem_rdata_i(32'h0000_0000),
    .stall_v_o(p_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted load transactions to address 0x2000.
  always @(posedge clk) begin
    if (rst_n && mem_req && gnt && !mem_we && mem_addr == 32'h2000) load_issue_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_r_v = 0; dmem_r_v = 0; dmem_w_v = 0; gnt = 0; rvalid = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wmask = 0; rdata = 0;
    p_imem_r_v = 0; p_dmem_r_v = 0; p_gnt = 0; p_rvalid = 0; p_imem_addr = 0; p_dmem_addr = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_iready", imem_ready, 0);
    check_eq("rst_dready", dmem_ready, 0);
    check_eq("rst_stall", stall, 0);
    imem_r_v = 1; #1;
    check_eq("rst_stall_req", stall, 1);
    imem_r_v = 0;
    @(negedge clk) rst_n = 1'b1;
    $display("[tb] reset checks done");

    // Fetch only
    cyc(); imem_r_v = 1; imem_addr = 32'h100; gnt = 1; #1;
    check_eq("f_c0_stall", stall, 1);
    check_eq("f_c0_req", mem_req, 0);
    cyc(); #1;
    check_eq("f_c1_req", mem_req, 1);
    check_eq("f_c1_addr", mem_addr, 32'h100);
    check_eq("f_c1_we", mem_we, 0);
    check_eq("f_c1_stall", stall, 1);
    cyc(); rvalid = 1; rdata = 32'h00500093; #1;
    check_eq("f_c2_iready", imem_ready, 1);
    check_eq("f_c2_idata", imem_data, 32'h00500093);
    check_eq("f_c2_stall", stall, 0);
    cyc(); imem_r_v = 0; rvalid = 0; #1;
    check_eq("f_c3_req", mem_req, 0);
    check_eq("f_c3_iready", imem_ready, 0);
    $display("[tb] fetch-only transaction done");

    // Simultaneous requests, dmem wins
    cyc(); imem_r_v = 1; imem_addr = 32'h104; dmem_r_v = 1; dmem_addr = 32'h2000; gnt = 1; snap = load_issue_cnt; #1;
    check_eq("s_c0_stall", stall, 1);
    cyc(); #1;
    check_eq("s_c1_req", mem_req, 1);
    check_eq("s_c1_addr", mem_addr, 32'h2000);
    cyc(); rvalid = 1; rdata = 32'h11112222; #1;
    check_eq("s_c2_dready", dmem_ready, 1);
    check_eq("s_c2_ddata", dmem_data, 32'h11112222);
    check_eq("s_c2_iready", imem_ready, 0);
    check_eq("s_c2_stall", stall, 1);
    cyc(); rvalid = 0; #1;
    check_eq("s_c3_req", mem_req, 0);
    check_eq("s_c3_dready", dmem_ready, 0);
    check_eq("s_c3_stall", stall, 1);
    cyc(); #1;
    check_eq("s_c4_req", mem_req, 1);
    check_eq("s_c4_addr", mem_addr, 32'h104);
    cyc(); rvalid = 1; rdata = 32'h33334444; #1;
    check_eq("s_c5_iready", imem_ready, 1);
    check_eq("s_c5_dready", dmem_ready, 0);
    check_eq("s_c5_stall", stall, 0);
    cyc(); imem_r_v = 0; dmem_r_v = 0; rvalid = 0; #1;
    check_eq("s_c6_req", mem_req, 0);
    check_eq("s_load_once", load_issue_cnt - snap, 1);
    $display("[tb] simultaneous dmem-first transactions done");

    // Store with gnt withheld for three cycles
    cyc(); dmem_w_v = 1; dmem_addr = 32'h2004; dmem_wdata = 32'hDEADBEEF; dmem_wmask = 4'b0011; gnt = 0; #1;
    check_eq("w_c0_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq("w_wait_req", mem_req, 1);
      check_eq("w_wait_we", mem_we, 1);
      check_eq("w_wait_addr", mem_addr, 32'h2004);
      check_eq("w_wait_wdata", mem_wdata, 32'hDEADBEEF);
      check_eq("w_wait_wmask", mem_wmask, 4'b0011);
    end
    cyc(); gnt = 1; #1;
    check_eq("w_gnt_req", mem_req, 1);
    cyc(); gnt = 0; rvalid = 1; #1;
    check_eq("w_resp_dready", dmem_ready, 1);
    check_eq("w_resp_req", mem_req, 0);
    check_eq("w_resp_stall", stall, 0);
    cyc(); dmem_w_v = 0; dmem_wmask = 0; rvalid = 0; #1;
    $display("[tb] store with backpressure done");

    // Back-to-back identical loads
    cyc(); dmem_r_v = 1; dmem_addr = 32'h2000; gnt = 1; #1;
    cyc(); #1;
    check_eq("b_c1_req", mem_req, 1);
    cyc(); rvalid = 1; rdata = 32'h0000000A; #1;
    check_eq("b_c2_dready", dmem_ready, 1);
    check_eq("b_c2_stall", stall, 0);
    cyc(); rvalid = 0; #1;
    check_eq("b_c3_stall", stall, 1);
    check_eq("b_c3_req", mem_req, 0);
    cyc(); #1;
    check_eq("b_c4_req", mem_req, 1);
    check_eq("b_c4_addr", mem_addr, 32'h2000);
    cyc(); rvalid = 1; rdata = 32'h0000000B; #1;
    check_eq("b_c5_dready", dmem_ready, 1);
    check_eq("b_c5_ddata", dmem_data, 32'h0000000B);
    cyc(); dmem_r_v = 0; rvalid = 0; #1;
    $display("[tb] back-to-back loads done");

    // Reset while waiting in RESP, then late rvalid and a dropped request
    cyc(); imem_r_v = 1; imem_addr = 32'h300; gnt = 1; #1;
    cyc(); #1;
    check_eq("r_c1_req", mem_req, 1);
    cyc(); #1;
    check_eq("r_c2_req", mem_req, 0);
    check_eq("r_c2_stall", stall, 1);
    rst_n = 0; #1;
    check_eq("r_async_req", mem_req, 0);
    check_eq("r_async_we", mem_we, 0);
    check_eq("r_async_addr", mem_addr, 0);
    rvalid = 1; #1;
    check_eq("r_async_iready", imem_ready, 0);
    cyc(); rst_n = 1; rvalid = 1; #1;
    check_eq("r_late_iready", imem_ready, 0);
    check_eq("r_late_stall", stall, 1);
    cyc(); imem_r_v = 0; rvalid = 0; gnt = 0; #1;
    check_eq("r_drop_req", mem_req, 1);
    cyc(); gnt = 1; #1;
    cyc(); gnt = 0; rvalid = 1; #1;
    check_eq("r_drop_iready", imem_ready, 0);
    check_eq("r_drop_stall", stall, 0);
    cyc(); rvalid = 0; #1;
    check_eq("r_drop_idle", mem_req, 0);
    $display("[tb] reset-in-resp transaction done");

    // Fetch priority instance
    cyc(); p_imem_r_v = 1; p_imem_addr = 32'h104; p_dmem_r_v = 1; p_dmem_addr = 32'h2000; p_gnt = 1; #1;
    check_eq("p_c0_stall", p_stall, 1);
    cyc(); #1;
    check_eq("p_c1_req", p_mem_req, 1);
    check_eq("p_c1_addr", p_mem_addr, 32'h104);
    cyc(); p_rvalid = 1; #1;
    check_eq("p_c2_iready", p_imem_ready, 1);
    check_eq("p_c2_dready", p_dmem_ready, 0);
    check_eq("p_c2_stall", p_stall, 1);
    cyc(); p_rvalid = 0; #1;
    cyc(); #1;
    check_eq("p_c4_addr", p_mem_addr, 32'h2000);
    check_eq("p_c4_req", p_mem_req, 1);
    $display("[tb] fetch-priority tie-break done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
